// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with opcode decode, load-use stall detection and branch flush.
// Bubbles are inserted by zeroing the registered control bits; counters record each inserted bubble.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCSrc,
    input  logic [31:0]      PC_ID,
    input  logic [31:0]      REG_DATA1_ID,
    input  logic [31:0]      REG_DATA2_ID,
    input  logic [31:0]      IMM_ID,
    input  logic [2:0]       FUNCT3_ID,
    input  logic [6:0]       FUNCT7_ID,
    input  logic [6:0]       OPCODE_ID,
    input  logic [4:0]       RD_ID,
    input  logic [4:0]       RS1_ID,
    input  logic [4:0]       RS2_ID,
    output logic [31:0]      PC_EX,
    output logic [31:0]      REG_DATA1_EX,
    output logic [31:0]      REG_DATA2_EX,
    output logic [31:0]      IMM_EX,
    output logic [2:0]       FUNCT3_EX,
    output logic [6:0]       FUNCT7_EX,
    output logic [4:0]       RD_EX,
    output logic [4:0]       RS1_EX,
    output logic [4:0]       RS2_EX,
    output logic             RegWrite_EX,
    output logic             MemRead_EX,
    output logic             MemWrite_EX,
    output logic             MemtoReg_EX,
    output logic             ALUSrc_EX,
    output logic             Branch_EX,
    output logic [1:0]       ALUOp_EX,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Control vector layout: {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, ALUOp[1:0]}
    logic [7:0]       w_ctrl_id;
    logic             w_rs1_used;
    logic             w_rs2_used;
    logic             w_hazard;
    logic             w_bubble;
    logic             w_stall_inc;

    logic [31:0]      r_pc;
    logic [31:0]      r_data1;
    logic [31:0]      r_data2;
    logic [31:0]      r_imm;
    logic [2:0]       r_funct3;
    logic [6:0]       r_funct7;
    logic [4:0]       r_rd;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [7:0]       r_ctrl;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_comb begin
        w_ctrl_id  = 8'b0;
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        case (OPCODE_ID)
            OP_R: begin
                w_ctrl_id  = 8'b1000_0010;
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
            end
            OP_I_ALU: begin
                w_ctrl_id  = 8'b1000_1011;
                w_rs1_used = 1'b1;
            end
            OP_LOAD: begin
                w_ctrl_id  = 8'b1101_1000;
                w_rs1_used = 1'b1;
            end
            OP_STORE: begin
                w_ctrl_id  = 8'b0010_1000;
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
            end
            OP_BRANCH: begin
                w_ctrl_id  = 8'b0000_0101;
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
            end
            default: begin
                w_ctrl_id  = 8'b0;
                w_rs1_used = 1'b0;
                w_rs2_used = 1'b0;
            end
        endcase
    end

    // A load into x0 never produces a value worth waiting for.
    assign w_hazard = r_ctrl[6] && (r_rd != 5'd0) &&
                      ((w_rs1_used && (r_rd == RS1_ID)) || (w_rs2_used && (r_rd == RS2_ID)));
    assign w_bubble    = PCSrc || w_hazard;
    assign w_stall_inc = w_hazard && !PCSrc;

    assign PC_write    = reset || PCSrc || !w_hazard;
    assign IF_ID_write = reset || PCSrc || !w_hazard;
    assign IF_ID_flush = !reset && PCSrc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= '0;
            r_data1     <= '0;
            r_data2     <= '0;
            r_imm       <= '0;
            r_funct3    <= '0;
            r_funct7    <= '0;
            r_rd        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_ctrl      <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_pc     <= PC_ID;
            r_data1  <= REG_DATA1_ID;
            r_data2  <= REG_DATA2_ID;
            r_imm    <= IMM_ID;
            r_funct3 <= FUNCT3_ID;
            r_funct7 <= FUNCT7_ID;
            r_rd     <= RD_ID;
            r_rs1    <= RS1_ID;
            r_rs2    <= RS2_ID;
            r_ctrl   <= w_bubble ? 8'b0 : w_ctrl_id;
            if (PCSrc && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
            if (w_stall_inc && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign PC_EX        = r_pc;
    assign REG_DATA1_EX = r_data1;
    assign REG_DATA2_EX = r_data2;
    assign IMM_EX       = r_imm;
    assign FUNCT3_EX    = r_funct3;
    assign FUNCT7_EX    = r_funct7;
    assign RD_EX        = r_rd;
    assign RS1_EX       = r_rs1;
    assign RS2_EX       = r_rs2;
    assign {RegWrite_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX, ALUSrc_EX, Branch_EX, ALUOp_EX} = r_ctrl;
    assign STALL_CNT    = r_stall_cnt;
    assign FLUSH_CNT    = r_flush_cnt;

endmodule
